// File: rtl/dac_pacer.sv
// -----------------------------------------------------------------------------
// dac_pacer
//
// Sits between the DUC output stream and the DAC. Samples are buffered in a
// small FIFO and released one per DAC update tick. The tick comes from a
// programmable down-counter (a tick every rate_div+1 cycles). A small
// IDLE/PRIME/RUN controller makes start-up priming and underflow behave
// deterministically, so the DAC never sees a stalled or garbage sample.
//
// Optional feature (macro DAC_PACER_UNDERFLOW_CNT_EN):
//   adds underflow_count_out, a 16-bit saturating count of underflow pulses,
//   cleared by reset and by a rising edge of enable.
//
// Ports:
//   clk                 system clock
//   arst_n              asynchronous active-low reset
//   enable              run control, level-sensitive
//   rate_div            tick period minus one, sampled at counter reload
//   src_data_in         signed sample from the DUC
//   src_valid_in        src_data_in is valid
//   src_ready_out       FIFO can accept a sample (registered state only)
//   dac_data_out        registered sample to the DAC
//   dac_strobe_out      one-cycle pulse: dac_data_out updated this cycle
//   underflow_out       one-cycle pulse: a tick found the FIFO empty
//   fill_level_out      FIFO occupancy, 0..DEPTH
//   underflow_count_out (optional) saturating underflow count
// -----------------------------------------------------------------------------
module dac_pacer #(
   parameter int DATA_WIDTH     = 16,
   parameter int DEPTH          = 16,
   parameter int RATE_W         = 8,
   parameter int PRIME_LEVEL    = 8,
   parameter int UNDERFLOW_MODE = 0
) (
   input  logic                         clk,
   input  logic                         arst_n,
   input  logic                         enable,
   input  logic [RATE_W-1:0]            rate_div,
   input  logic signed [DATA_WIDTH-1:0] src_data_in,
   input  logic                         src_valid_in,
   output logic                         src_ready_out,
   output logic signed [DATA_WIDTH-1:0] dac_data_out,
   output logic                         dac_strobe_out,
   output logic                         underflow_out,
   output logic [$clog2(DEPTH):0]       fill_level_out
`ifdef DAC_PACER_UNDERFLOW_CNT_EN
   ,
   output logic [15:0]                  underflow_count_out
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRIME = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   // Value driven on an underflow tick: zero, or the last sample held.
   function automatic logic signed [DATA_WIDTH-1:0] underflow_value(
      input logic signed [DATA_WIDTH-1:0] last_sample
   );
      if (UNDERFLOW_MODE == 1) return last_sample;
      else                     return '0;
   endfunction

   state_t                         state_q, state_d;
   logic [PW-1:0]                  wr_ptr_q, rd_ptr_q;
   logic [PW-1:0]                  fill;
   logic                           full;
   logic                           wr_en;
   logic                           pop;
   logic                           uf_evt;
   logic                           strobe_d;
   logic signed [DATA_WIDTH-1:0]   data_d;
   logic [RATE_W-1:0]              cnt_q;
   logic                           tick;
   logic signed [DATA_WIDTH-1:0]   mem [DEPTH];

   // ---- FIFO: pointers carry a wrap bit, so fill is a plain difference ----
   assign fill           = wr_ptr_q - rd_ptr_q;
   assign full           = (fill == PW'(DEPTH));
   assign src_ready_out  = !full;
   assign fill_level_out = fill;
   assign wr_en          = src_valid_in && src_ready_out;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q[AW-1:0]] <= src_data_in;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // ---- Tick counter: runs only in RUN, parked at 0 otherwise ----
   // Parking at 0 makes the first RUN cycle a tick.
   assign tick = (cnt_q == '0);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)               cnt_q <= '0;
      else if (state_q != S_RUN) cnt_q <= '0;
      else if (tick)             cnt_q <= rate_div;
      else                       cnt_q <= cnt_q - 1'b1;
   end

   // ---- Controller: next state and next output values ----
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      uf_evt   = 1'b0;
      strobe_d = 1'b0;
      data_d   = dac_data_out;
      case (state_q)
         S_IDLE: begin
            data_d = '0;
            if (enable) state_d = S_PRIME;
         end
         S_PRIME: begin
            if (!enable) begin
               state_d = S_IDLE;
               data_d  = '0;
            end else if (fill >= PW'(PRIME_LEVEL)) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Dropping enable wins over a coincident tick.
            if (!enable) begin
               state_d = S_IDLE;
               data_d  = '0;
            end else if (tick) begin
               strobe_d = 1'b1;
               if (fill != '0) begin
                  pop    = 1'b1;
                  data_d = mem[rd_ptr_q[AW-1:0]];
               end else begin
                  uf_evt  = 1'b1;
                  data_d  = underflow_value(dac_data_out);
                  state_d = S_PRIME;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            data_d  = '0;
         end
      endcase
   end

   // ---- Output register stage ----
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         dac_data_out   <= '0;
         dac_strobe_out <= 1'b0;
         underflow_out  <= 1'b0;
      end else begin
         dac_data_out   <= data_d;
         dac_strobe_out <= strobe_d;
         underflow_out  <= uf_evt;
      end
   end

`ifdef DAC_PACER_UNDERFLOW_CNT_EN
   // Saturating increment: the count sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      if (v == 16'hFFFF) return v;
      else               return v + 16'd1;
   endfunction

   logic        enable_q;
   logic [15:0] uf_cnt_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         enable_q <= 1'b0;
         uf_cnt_q <= '0;
      end else begin
         enable_q <= enable;
         if (enable && !enable_q) uf_cnt_q <= '0;
         else if (uf_evt)         uf_cnt_q <= sat_inc(uf_cnt_q);
      end
   end

   assign underflow_count_out = uf_cnt_q;
`endif

endmodule

// File: tb/tb_dac_pacer.sv
// -----------------------------------------------------------------------------
// tb_dac_pacer
//
// Two dac_pacer instances share the same stimulus: dut0 with UNDERFLOW_MODE=0
// and dut1 with UNDERFLOW_MODE=1. A queue-based reference model predicts the
// outputs of both every cycle. Scenario tasks add targeted checks on top.
// -----------------------------------------------------------------------------
module tb_dac_pacer;

   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int RW    = 8;
   localparam int PL    = 8;
   localparam int FW    = $clog2(DEPTH) + 1;
`ifdef DAC_PACER_UNDERFLOW_CNT_EN
   localparam int VW    = 2*DW + 2*(FW+3) + 16;
`else
   localparam int VW    = 2*DW + 2*(FW+3);
`endif

   logic          clk       = 1'b0;
   logic          arst_n    = 1'b0;
   logic          enable    = 1'b0;
   logic [RW-1:0] rate_div  = '0;
   logic [DW-1:0] src_data  = '0;
   logic          src_valid = 1'b0;

   logic          rdy0, rdy1, stb0, stb1, uf0, uf1;
   logic [DW-1:0] d0, d1;
   logic [FW-1:0] fill0, fill1;
`ifdef DAC_PACER_UNDERFLOW_CNT_EN
   logic [15:0]   ucnt0, ucnt1;
`endif

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   dac_pacer #(.UNDERFLOW_MODE(0)) dut0 (
      .clk(clk), .arst_n(arst_n), .enable(enable), .rate_div(rate_div),
      .src_data_in(src_data), .src_valid_in(src_valid), .src_ready_out(rdy0),
      .dac_data_out(d0), .dac_strobe_out(stb0), .underflow_out(uf0),
      .fill_level_out(fill0)
`ifdef DAC_PACER_UNDERFLOW_CNT_EN
      , .underflow_count_out(ucnt0)
`endif
   );

   dac_pacer #(.UNDERFLOW_MODE(1)) dut1 (
      .clk(clk), .arst_n(arst_n), .enable(enable), .rate_div(rate_div),
      .src_data_in(src_data), .src_valid_in(src_valid), .src_ready_out(rdy1),
      .dac_data_out(d1), .dac_strobe_out(stb1), .underflow_out(uf1),
      .fill_level_out(fill1)
`ifdef DAC_PACER_UNDERFLOW_CNT_EN
      , .underflow_count_out(ucnt1)
`endif
   );

   // ---------------- reference model ----------------
   // phase: 0 = stopped, 1 = waiting for fill to reach PL, 2 = pacing.
   // left: cycles remaining until the next DAC update while pacing.
   logic [DW-1:0] q[$];
   int            phase    = 0;
   int            left     = 0;
   int            m_sz     = 0;
   bit            m_acc    = 0;
   logic [DW-1:0] m_d0     = '0;
   logic [DW-1:0] m_d1     = '0;
   logic          m_stb    = 1'b0;
   logic          m_uf     = 1'b0;
   logic [15:0]   m_ucnt   = '0;
   logic          m_en_prev = 1'b0;

   always @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         q.delete();
         phase = 0; left = 0;
         m_d0 = '0; m_d1 = '0; m_stb = 1'b0; m_uf = 1'b0;
         m_ucnt = '0; m_en_prev = 1'b0;
      end else begin
         m_sz  = q.size();
         m_acc = src_valid && (m_sz < DEPTH);
         m_stb = 1'b0;
         m_uf  = 1'b0;
         if (enable && !m_en_prev) m_ucnt = '0;
         m_en_prev = enable;
         if (phase == 0) begin
            m_d0 = '0; m_d1 = '0;
            if (enable) phase = 1;
         end else if (!enable) begin
            phase = 0; m_d0 = '0; m_d1 = '0;
         end else if (phase == 1) begin
            if (m_sz >= PL) begin phase = 2; left = 0; end
         end else begin
            if (left == 0) begin
               left  = int'(rate_div);
               m_stb = 1'b1;
               if (m_sz > 0) begin
                  m_d0 = q.pop_front();
                  m_d1 = m_d0;
               end else begin
                  m_uf  = 1'b1;
                  m_d0  = '0;
                  phase = 1;
                  if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
               end
            end else begin
               left = left - 1;
            end
         end
         if (m_acc) q.push_back(src_data);
      end
   end

   function automatic logic [VW-1:0] dut_vec();
      return {d0, d1, stb0, uf0, fill0, rdy0, stb1, uf1, fill1, rdy1
`ifdef DAC_PACER_UNDERFLOW_CNT_EN
              , ucnt0
`endif
             };
   endfunction

   function automatic logic [VW-1:0] ref_vec();
      logic r;
      r = (q.size() < DEPTH);
      return {m_d0, m_d1, m_stb, m_uf, FW'(q.size()), r, m_stb, m_uf, FW'(q.size()), r
`ifdef DAC_PACER_UNDERFLOW_CNT_EN
              , m_ucnt
`endif
             };
   endfunction

   function automatic bit will_accept();
      return src_valid && (q.size() < DEPTH);
   endfunction

   // Put the DUTs back into reset for one cycle; inputs parked.
   task automatic do_reset();
      @(negedge clk);
      arst_n = 1'b0; enable = 1'b0; src_valid = 1'b0; rate_div = '0;
      @(negedge clk);
      arst_n = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      arst_n = 1'b0;
      #1;
      vectors++;
      if (d0 !== '0 || d1 !== '0 || stb0 !== 1'b0 || uf0 !== 1'b0 || fill0 !== '0 || rdy0 !== 1'b1 ||
          stb1 !== 1'b0 || uf1 !== 1'b0 || fill1 !== '0 || rdy1 !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_state: got d0=%h d1=%h stb=%b uf=%b fill=%0d rdy=%b, want 0/0/0/0/0/1",
                  d0, d1, stb0, uf0, fill0, rdy0);
      end
      @(negedge clk);
      arst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vectors++;
         if (dut_vec() !== ref_vec()) begin
            miscompares++;
            $display("FAIL reset_idle cycle %0d: dut=%h ref=%h", i, dut_vec(), ref_vec());
         end
      end
   endtask

   task automatic test_prime_and_pace();
      int idx = 0, nstb = 0, last = -1;
      bit acc;
      do_reset();
      rate_div = 8'd3;
      enable   = 1'b1;
      for (int i = 0; i < 70; i++) begin
         src_valid = (idx < 12);
         src_data  = DW'(idx + 1);
         acc = will_accept();
         @(negedge clk);
         if (acc) idx++;
         vectors++;
         if (dut_vec() !== ref_vec()) begin
            miscompares++;
            $display("FAIL prime_pace cycle %0d: dut=%h ref=%h", i, dut_vec(), ref_vec());
         end
         if (stb0) begin
            vectors++;
            if (idx < PL || (last >= 0 && i - last != 4)) begin
               miscompares++;
               $display("FAIL pace_timing cycle %0d: accepted=%0d gap=%0d, want >=%0d and 4",
                        i, idx, i - last, PL);
            end
            last = i;
            if (!uf0) begin
               nstb++;
               vectors++;
               if (d0 !== DW'(nstb)) begin
                  miscompares++;
                  $display("FAIL pace_order strobe %0d: got %h want %h", nstb, d0, DW'(nstb));
               end
            end
         end
      end
      vectors++;
      if (nstb != 12) begin
         miscompares++;
         $display("FAIL pace_count: got %0d strobes want 12", nstb);
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] sent [20];
      int idx = 0, nout = 0;
      bit acc;
      do_reset();
      for (int k = 0; k < 20; k++) sent[k] = DW'($urandom);
      rate_div = RW'($urandom_range(0, 5));
      for (int i = 0; i < 300; i++) begin
         enable    = (i >= 25);
         src_valid = (idx < 20);
         src_data  = (idx < 20) ? sent[idx] : '0;
         acc = will_accept();
         @(negedge clk);
         if (acc) idx++;
         vectors++;
         if (dut_vec() !== ref_vec()) begin
            miscompares++;
            $display("FAIL backpressure cycle %0d: dut=%h ref=%h", i, dut_vec(), ref_vec());
         end
         if (i == 20) begin
            vectors++;
            if (rdy0 !== 1'b0 || fill0 !== FW'(16) || idx != 16) begin
               miscompares++;
               $display("FAIL bp_full: rdy=%b fill=%0d accepted=%0d, want 0/16/16", rdy0, fill0, idx);
            end
         end
         if (stb0 && !uf0) begin
            vectors++;
            if (nout >= 20 || d0 !== sent[nout]) begin
               miscompares++;
               $display("FAIL bp_order out %0d: got %h want %h", nout, d0, (nout < 20) ? sent[nout] : '0);
            end
            nout++;
         end
      end
      vectors++;
      if (nout != 20) begin
         miscompares++;
         $display("FAIL bp_count: got %0d samples out want 20", nout);
      end
   endtask

   task automatic test_underflow();
      int idx = 0, nstb = 0;
      bit acc;
      do_reset();
      rate_div = 8'd0;
      enable   = 1'b1;
      for (int i = 0; i < 40; i++) begin
         src_valid = (idx < 8);
         src_data  = (idx == 7) ? 16'h8001 : 16'h7FFF;
         acc = will_accept();
         @(negedge clk);
         if (acc) idx++;
         vectors++;
         if (dut_vec() !== ref_vec()) begin
            miscompares++;
            $display("FAIL underflow cycle %0d: dut=%h ref=%h", i, dut_vec(), ref_vec());
         end
         if (stb0) begin
            nstb++;
            vectors++;
            if (nstb < 8 && (d0 !== 16'h7FFF || uf0 !== 1'b0)) begin
               miscompares++;
               $display("FAIL uf_data strobe %0d: got %h uf=%b want 7fff uf=0", nstb, d0, uf0);
            end else if (nstb == 9 && (uf0 !== 1'b1 || d0 !== 16'h0000 || d1 !== 16'h8001)) begin
               miscompares++;
               $display("FAIL uf_strobe: uf=%b d0=%h d1=%h want 1/0000/8001", uf0, d0, d1);
            end else if (nstb > 9) begin
               miscompares++;
               $display("FAIL uf_extra: strobe %0d seen, want none after underflow", nstb);
            end
         end
      end
      vectors++;
      if (nstb != 9) begin
         miscompares++;
         $display("FAIL uf_count: got %0d strobes want 9", nstb);
      end
`ifdef DAC_PACER_UNDERFLOW_CNT_EN
      vectors++;
      if (ucnt0 !== 16'd1 || ucnt1 !== 16'd1) begin
         miscompares++;
         $display("FAIL uf_counter: got %0d/%0d want 1", ucnt0, ucnt1);
      end
`endif
   endtask

   task automatic test_enable_drop();
      int idx = 0, n = 0, nlate = 0;
      bit acc;
      do_reset();
      rate_div = 8'd7;
      enable   = 1'b1;
      for (int i = 0; i < 200 && n < 3; i++) begin
         src_valid = (idx < 8);
         src_data  = DW'($urandom);
         acc = will_accept();
         @(negedge clk);
         if (acc) idx++;
         vectors++;
         if (dut_vec() !== ref_vec()) begin
            miscompares++;
            $display("FAIL en_drop_fill cycle %0d: dut=%h ref=%h", i, dut_vec(), ref_vec());
         end
         if (stb0) n++;
      end
      src_valid = 1'b0;
      vectors++;
      if (n != 3) begin
         miscompares++;
         $display("FAIL en_drop_wait: got %0d strobes within budget want 3", n);
      end
      repeat (7) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      vectors++;
      if (stb0 !== 1'b0 || d0 !== '0 || fill0 !== FW'(5) || dut_vec() !== ref_vec()) begin
         miscompares++;
         $display("FAIL en_drop: stb=%b data=%h fill=%0d, want 0/0000/5", stb0, d0, fill0);
      end
      enable = 1'b1;
      idx = 0;
      for (int i = 0; i < 60; i++) begin
         src_valid = (i >= 10) && (idx < 3);
         src_data  = DW'($urandom);
         acc = will_accept();
         @(negedge clk);
         if (acc) idx++;
         vectors++;
         if (dut_vec() !== ref_vec() || (i < 10 && stb0 !== 1'b0)) begin
            miscompares++;
            $display("FAIL en_resume cycle %0d: dut=%h ref=%h", i, dut_vec(), ref_vec());
         end
         if (stb0) nlate++;
      end
      vectors++;
      if (nlate == 0) begin
         miscompares++;
         $display("FAIL en_resume_run: got 0 strobes after refill want >0");
      end
   endtask

   task automatic test_async_reset();
      int idx = 0;
      bit acc;
      do_reset();
      rate_div = 8'd15;
      enable   = 1'b1;
      for (int i = 0; i < 14; i++) begin
         src_valid = (idx < 11);
         src_data  = DW'($urandom_range(1, 16'hFFFF));
         acc = will_accept();
         @(negedge clk);
         if (acc) idx++;
         vectors++;
         if (dut_vec() !== ref_vec()) begin
            miscompares++;
            $display("FAIL async_pre cycle %0d: dut=%h ref=%h", i, dut_vec(), ref_vec());
         end
      end
      vectors++;
      if (fill0 !== FW'(10) || d0 === '0) begin
         miscompares++;
         $display("FAIL async_setup: fill=%0d data=%h, want fill 10 and nonzero data", fill0, d0);
      end
      #2 arst_n = 1'b0;
      #1;
      vectors++;
      if (d0 !== '0 || d1 !== '0 || stb0 !== 1'b0 || uf0 !== 1'b0 || fill0 !== '0 || fill1 !== '0) begin
         miscompares++;
         $display("FAIL async_reset: d0=%h d1=%h stb=%b uf=%b fill=%0d, want all 0", d0, d1, stb0, uf0, fill0);
      end
      enable = 1'b0;
      @(negedge clk);
      arst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         vectors++;
         if (dut_vec() !== ref_vec() || rdy0 !== 1'b1 || stb0 !== 1'b0) begin
            miscompares++;
            $display("FAIL async_after cycle %0d: dut=%h ref=%h", i, dut_vec(), ref_vec());
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) rate_div = RW'($urandom_range(0, 3));
         if ($urandom_range(0, 63) == 0) enable = !enable;
         src_valid = ($urandom_range(0, 3) != 0);
         src_data  = DW'($urandom);
         @(negedge clk);
         vectors++;
         if (dut_vec() !== ref_vec()) begin
            miscompares++;
            $display("FAIL random cycle %0d: dut=%h ref=%h", i, dut_vec(), ref_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_prime_and_pace();
      test_backpressure();
      test_underflow();
      test_enable_drop();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
